spi_rgb_regfile: RTL and testbench



---
 rtl/rgb_pkg.sv | 21 ++
 rtl/rgb_colour_bank.sv | 54 +++++
 rtl/spi_rgb_regfile.sv | 114 +++++++++++
 tb/tb_spi_rgb_regfile.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared constants and types for the SPI-to-RGB register file.
package rgb_pkg;
  localparam logic [6:0] ADDR_STATUS = 7'h7E;
  localparam logic [6:0] ADDR_CTRL   = 7'h7F;

  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_CLR_ERR = 1;
  localparam int CTRL_CLR_ALL = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_PEND = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
endpackage

// File: rtl/rgb_colour_bank.sv
// Colour byte store: SPI byte write/read, bulk load, clear, registered per-LED read.
module rgb_colour_bank
  import rgb_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int IDX_W    = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           wr_en,
  input  logic [6:0]                     wr_addr,
  input  logic [7:0]                     wr_data,
  input  logic                           copy_en,
  input  logic [3*NUM_LEDS-1:0][7:0]     copy_data,
  output logic [3*NUM_LEDS-1:0][7:0]     mem_q,
  input  logic [6:0]                     byte_addr,
  output logic [7:0]                     byte_q,
  input  logic [IDX_W-1:0]               rd_idx,
  output rgb_t                           rd_rgb
);
  localparam int NB = 3 * NUM_LEDS;

  logic [NB-1:0][7:0] mem;
  rgb_t               rd_nxt;

  assign mem_q = mem;

  always_ff @(posedge clk) begin
    if (rst || clr) mem <= '0;
    else if (copy_en) mem <= copy_data;
    else if (wr_en)
      for (int i = 0; i < NB; i++)
        if (wr_addr == 7'(i)) mem[i] <= wr_data;
  end

  always_comb begin
    byte_q = '0;
    for (int i = 0; i < NB; i++)
      if (byte_addr == 7'(i)) byte_q = mem[i];
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i < NUM_LEDS; i++)
      if (rd_idx == IDX_W'(i)) rd_nxt = {mem[3*i], mem[3*i+1], mem[3*i+2]};
  end

  always_ff @(posedge clk) begin
    if (rst) rd_rgb <= '0;
    else     rd_rgb <= rd_nxt;
  end
endmodule

// File: rtl/spi_rgb_regfile.sv
// SPI frame decoder and LED colour register file with deferred update strobe.
// Define SPI_RGB_SHADOW_EN to double-buffer colours, swapping on led_update.
module spi_rgb_regfile
  import rgb_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int IDX_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_active,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic [7:0]       tx_data,
  output logic             tx_load,
  input  logic [IDX_W-1:0] led_rd_idx,
  output logic [23:0]      led_rd_rgb,
  input  logic             led_busy,
  output logic             led_update,
  output logic             err
);
  state_t     state;
  logic [6:0] addr;
  logic       fa_d, pending;

  logic [6:0] acc_addr;
  logic [7:0] byte_q, rd_val;
  logic       is_colour, unmapped, do_rd, do_wr, ctrl_wr, clr_all, fire;

  // In CMD the command byte itself carries the first read address.
  assign acc_addr  = (state == CMD) ? rx_data[6:0] : addr;
  assign is_colour = acc_addr < 7'(3 * NUM_LEDS);
  assign unmapped  = !is_colour && acc_addr != ADDR_STATUS && acc_addr != ADDR_CTRL;
  assign do_rd     = frame_active && rx_valid &&
                     ((state == CMD && rx_data[7]) || state == RD);
  assign do_wr     = frame_active && rx_valid && state == WR;
  assign ctrl_wr   = do_wr && addr == ADDR_CTRL;
  assign clr_all   = ctrl_wr && rx_data[CTRL_CLR_ALL];
  assign fire      = pending && !led_busy;

  always_comb begin
    rd_val = '0;
    if (acc_addr == ADDR_STATUS) begin
      rd_val[STAT_BUSY] = led_busy;
      rd_val[STAT_PEND] = pending;
      rd_val[STAT_ERR]  = err;
    end else if (is_colour) begin
      rd_val = byte_q;
    end
  end

`ifdef SPI_RGB_SHADOW_EN
  logic [3*NUM_LEDS-1:0][7:0] shadow_q;

  rgb_colour_bank #(.NUM_LEDS(NUM_LEDS), .IDX_W(IDX_W)) u_shadow (
    .clk(clk), .rst(rst), .clr(clr_all),
    .wr_en(do_wr && is_colour), .wr_addr(addr), .wr_data(rx_data),
    .copy_en(1'b0), .copy_data('0), .mem_q(shadow_q),
    .byte_addr(acc_addr), .byte_q(byte_q),
    .rd_idx('0), .rd_rgb()
  );

  rgb_colour_bank #(.NUM_LEDS(NUM_LEDS), .IDX_W(IDX_W)) u_active (
    .clk(clk), .rst(rst), .clr(clr_all),
    .wr_en(1'b0), .wr_addr('0), .wr_data('0),
    .copy_en(fire), .copy_data(shadow_q), .mem_q(),
    .byte_addr('0), .byte_q(),
    .rd_idx(led_rd_idx), .rd_rgb(led_rd_rgb)
  );
`else
  rgb_colour_bank #(.NUM_LEDS(NUM_LEDS), .IDX_W(IDX_W)) u_bank (
    .clk(clk), .rst(rst), .clr(clr_all),
    .wr_en(do_wr && is_colour), .wr_addr(addr), .wr_data(rx_data),
    .copy_en(1'b0), .copy_data('0), .mem_q(),
    .byte_addr(acc_addr), .byte_q(byte_q),
    .rd_idx(led_rd_idx), .rd_rgb(led_rd_rgb)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      fa_d       <= 1'b0;
      pending    <= 1'b0;
      tx_data    <= '0;
      tx_load    <= 1'b0;
      led_update <= 1'b0;
      err        <= 1'b0;
    end else begin
      fa_d       <= frame_active;
      tx_load    <= do_rd;
      if (do_rd) tx_data <= rd_val;
      led_update <= fire;
      // A commit landing on the firing cycle re-arms pending.
      pending    <= (pending && !fire) || (ctrl_wr && rx_data[CTRL_COMMIT]);
      err        <= (err && !(ctrl_wr && rx_data[CTRL_CLR_ERR])) ||
                    ((do_rd || do_wr) && unmapped);

      if (!frame_active) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (!fa_d) state <= CMD;
          CMD: if (rx_valid) begin
            state <= rx_data[7] ? RD : WR;
            addr  <= rx_data[7] ? rx_data[6:0] + 7'd1 : rx_data[6:0];
          end
          default: if (rx_valid) addr <= addr + 7'd1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_rgb_regfile.sv
// Directed bench for spi_rgb_regfile (default single-bank build).
module tb_spi_rgb_regfile;
  logic        clk = 1'b0;
  logic        rst, frame_active, rx_valid, led_busy;
  logic [7:0]  rx_data;
  logic [5:0]  led_rd_idx;
  logic [7:0]  tx_data;
  logic        tx_load, led_update, err;
  logic [23:0] led_rd_rgb;

  int nvec = 0;
  int nerr = 0;
  int nupd;

  always #5 clk = ~clk;

  spi_rgb_regfile #(.NUM_LEDS(8), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .frame_active(frame_active),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .tx_load(tx_load),
    .led_rd_idx(led_rd_idx), .led_rd_rgb(led_rd_rgb),
    .led_busy(led_busy), .led_update(led_update), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_on();
    frame_active = 1'b1;
    idle(2);
  endtask

  task automatic frame_off();
    frame_active = 1'b0;
    idle(2);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic rd(input string tag, input logic [7:0] b, input logic [7:0] exp);
    send(b);
    chk({tag, "_load"}, 32'(tx_load), 32'd1);
    chk(tag, 32'(tx_data), 32'(exp));
    idle(1);
    chk({tag, "_load_off"}, 32'(tx_load), 32'd0);
  endtask

  task automatic count_upd(input int n);
    repeat (n) begin
      @(negedge clk);
      if (led_update) nupd++;
    end
  endtask

  initial begin
    rst = 1'b1; frame_active = 1'b0; rx_valid = 1'b0; rx_data = '0;
    led_busy = 1'b0; led_rd_idx = '0;
    idle(3);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_load", 32'(tx_load), 0);
    chk("rst_rgb", 32'(led_rd_rgb), 0);
    chk("rst_update", 32'(led_update), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    idle(2);

    // basic write of LED 0
    frame_on(); send(8'h00); send(8'h11); send(8'h22); send(8'h33); frame_off();
    chk("wr_led0", 32'(led_rd_rgb), 32'h112233);

    // last LED, then run past the map into unmapped space
    frame_on(); send(8'h15); send(8'hA1); send(8'hB2); send(8'hC3);
    chk("no_err_yet", 32'(err), 0);
    send(8'hDD); frame_off();
    chk("err_unmapped_wr", 32'(err), 1);
    led_rd_idx = 6'd7; idle(2);
    chk("wr_led7", 32'(led_rd_rgb), 32'hA1B2C3);
    led_rd_idx = 6'd8; idle(2);
    chk("idx_out_of_range", 32'(led_rd_rgb), 0);
    led_rd_idx = 6'd0;
    frame_on(); send(8'h7F); send(8'h02); frame_off();
    chk("err_cleared", 32'(err), 0);

    // read back
    frame_on();
    rd("rd_r0", 8'h80, 8'h11);
    rd("rd_g0", 8'h5A, 8'h22);
    rd("rd_b0", 8'hFF, 8'h33);
    rd("rd_r1", 8'h00, 8'h00);
    frame_off();
    chk("rd_no_err", 32'(err), 0);

    // commit deferred by busy, repeated commit merges
    nupd = 0;
    led_busy = 1'b1;
    frame_on(); send(8'h7F); send(8'h01); frame_off();
    count_upd(4);
    frame_on(); rd("status_busy_pend", 8'hFE, 8'h03); frame_off();
    frame_on(); send(8'h7F); send(8'h01); frame_off();
    count_upd(4);
    chk("no_update_while_busy", 32'(nupd), 0);
    led_busy = 1'b0;
    count_upd(10);
    chk("single_update", 32'(nupd), 1);
    frame_on(); rd("status_idle", 8'hFE, 8'h00); frame_off();
    frame_on(); rd("ctrl_reads_0", 8'hFF, 8'h00); frame_off();

    // CTRL write at wrap then address 0
    frame_on(); send(8'h7F); send(8'h00); send(8'hAA); frame_off();
    chk("wrap_led0", 32'(led_rd_rgb), 32'hAA2233);
    chk("wrap_no_err", 32'(err), 0);
    chk("wrap_no_pending_update", 32'(led_update), 0);

    // aborted frame; next frame's first byte is a fresh command
    frame_on(); send(8'h03); frame_off();
    frame_on(); send(8'h55);
    chk("abort_cmd_no_err", 32'(err), 0);
    send(8'h77); frame_off();
    chk("abort_err", 32'(err), 1);
    led_rd_idx = 6'd1; idle(2);
    chk("abort_led1_untouched", 32'(led_rd_rgb), 0);
    frame_on(); rd("status_err", 8'hFE, 8'h04); frame_off();
    frame_on(); send(8'h7F); send(8'h02); frame_off();
    chk("abort_err_clr", 32'(err), 0);

    // unmapped read returns 0 and sets err
    frame_on(); rd("rd_unmapped", 8'hE0, 8'h00); frame_off();
    chk("rd_unmapped_err", 32'(err), 1);
    frame_on(); send(8'h7F); send(8'h02); frame_off();

    // byte during IDLE is ignored
    send(8'h00); send(8'h99); idle(2);
    led_rd_idx = 6'd0; idle(2);
    chk("idle_byte_ignored", 32'(led_rd_rgb), 32'hAA2233);

    // clear_all
    frame_on(); send(8'h7F); send(8'h04); frame_off();
    chk("clr_all_led0", 32'(led_rd_rgb), 0);
    led_rd_idx = 6'd7; idle(2);
    chk("clr_all_led7", 32'(led_rd_rgb), 0);
    led_rd_idx = 6'd0;

    // reset mid-read
    frame_on(); send(8'h00); send(8'h12); send(8'h34); send(8'h56); frame_off();
    frame_on(); send(8'h60); send(8'h00); frame_off();
    chk("pre_rst_err", 32'(err), 1);
    frame_on(); rd("pre_rst_rd", 8'h80, 8'h12);
    send(8'h00);
    rst = 1'b1;
    @(negedge clk);
    chk("midrd_rst_tx_data", 32'(tx_data), 0);
    chk("midrd_rst_tx_load", 32'(tx_load), 0);
    chk("midrd_rst_err", 32'(err), 0);
    chk("midrd_rst_rgb", 32'(led_rd_rgb), 0);
    chk("midrd_rst_update", 32'(led_update), 0);
    rst = 1'b0; frame_active = 1'b0;
    idle(3);
    chk("post_rst_rgb", 32'(led_rd_rgb), 0);
    frame_on(); rd("post_rst_rd", 8'h80, 8'h00); frame_off();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
